// File: rtl/orv64_param_pkg.sv
// Shared orv64 sizing parameters used as defaults by the icache prefetch path.
package orv64_param_pkg;

  localparam int ORV64_N_ICACHE_PREFETCH  = 4;
  localparam int ORV64_ICACHE_LINE_WIDTH  = 256;
  localparam int ORV64_VIR_ADDR_WIDTH     = 39;
  localparam int ORV64_ICACHE_LINE_OFFSET = 5;

endpackage

// File: rtl/orv64_typedef_pkg.sv
// Shared orv64 type definitions.
package orv64_typedef_pkg;

  typedef enum logic [1:0] {
    ORV64_IC_PF_IDLE,
    ORV64_IC_PF_REQ,
    ORV64_IC_PF_WAIT,
    ORV64_IC_PF_DRAIN
  } orv64_ic_pf_state_t;

endpackage

// File: rtl/orv64_ic_pf_entry.sv
// One prefetched line: valid/tag/line storage, tag compare and 32-bit word select.
module orv64_ic_pf_entry #(
  parameter int LINE_W  = 256,
  parameter int TAG_W   = 34,
  parameter int WIDX_W  = $clog2(LINE_W / 32)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [TAG_W-1:0]  probe_tag,
  input  logic [WIDX_W-1:0] probe_word,
  output logic              hit,
  output logic [31:0]       word
);

  logic              valid;
  logic [TAG_W-1:0]  tag;
  logic [LINE_W-1:0] line;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (we) begin
      valid <= 1'b1;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  // NOTE: tag/line storage is deliberately not reset; valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (we) begin
      tag  <= wr_tag;
      line <= wr_line;
    end
  end

  assign hit  = valid && (tag == probe_tag);
  assign word = hit ? line[probe_word*32 +: 32] : 32'd0;

endmodule

// File: rtl/orv64_ic_prefetch_buf.sv
// Sequential next-line instruction prefetcher: after an icache miss it streams the
// following N_ENTRY lines into a small buffer that fetch can probe with 1-cycle latency.
module orv64_ic_prefetch_buf
  import orv64_param_pkg::*;
  import orv64_typedef_pkg::*;
#(
  parameter int N_ENTRY = ORV64_N_ICACHE_PREFETCH,
  parameter int LINE_W  = ORV64_ICACHE_LINE_WIDTH,
  parameter int ADDR_W  = ORV64_VIR_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              pf_req_valid,
  output logic [ADDR_W-1:0] pf_req_addr,
  input  logic              pf_req_ready,
  input  logic              pf_resp_valid,
  input  logic [LINE_W-1:0] pf_resp_line,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              lookup_rsp_valid,
  output logic              lookup_hit,
  output logic [31:0]       lookup_inst
);

  localparam int OFF_W  = ORV64_ICACHE_LINE_OFFSET;
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int WIDX_W = $clog2(LINE_W / 32);
  localparam int CNT_W  = $clog2(N_ENTRY + 1);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(32);

  orv64_ic_pf_state_t state, state_nxt;

  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  cnt;
  logic              pend;

  logic clr_all, load_addr, cnt_clr, advance, pend_set, pend_clr, wr_en;

  logic [ADDR_W-1:0] miss_next;
  assign miss_next = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + LINE_BYTES;

  logic unused_bits;
  assign unused_bits = ^{miss_addr[OFF_W-1:0], lookup_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= ORV64_IC_PF_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    clr_all   = 1'b0;
    load_addr = 1'b0;
    cnt_clr   = 1'b0;
    advance   = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    wr_en     = 1'b0;
    if (flush) begin
      // Flush beats any concurrent miss; an in-flight response still has to be drained.
      clr_all  = 1'b1;
      pend_clr = 1'b1;
      case (state)
        ORV64_IC_PF_WAIT,
        ORV64_IC_PF_DRAIN: state_nxt = pf_resp_valid ? ORV64_IC_PF_IDLE : ORV64_IC_PF_DRAIN;
        default:           state_nxt = ORV64_IC_PF_IDLE;
      endcase
    end else begin
      case (state)
        ORV64_IC_PF_IDLE: begin
          if (miss_valid) begin
            clr_all   = 1'b1;
            load_addr = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = ORV64_IC_PF_REQ;
          end
        end
        ORV64_IC_PF_REQ: begin
          if (pf_req_ready) begin
            // A miss coinciding with the handshake must wait for that response.
            state_nxt = ORV64_IC_PF_WAIT;
            if (miss_valid) begin
              load_addr = 1'b1;
              pend_set  = 1'b1;
            end
          end else if (miss_valid) begin
            clr_all   = 1'b1;
            load_addr = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        ORV64_IC_PF_WAIT: begin
          if (pf_resp_valid) begin
            if (pend || miss_valid) begin
              clr_all   = 1'b1;
              load_addr = miss_valid;
              cnt_clr   = 1'b1;
              pend_clr  = 1'b1;
              state_nxt = ORV64_IC_PF_REQ;
            end else begin
              wr_en     = 1'b1;
              advance   = 1'b1;
              state_nxt = (cnt == CNT_W'(N_ENTRY - 1)) ? ORV64_IC_PF_IDLE : ORV64_IC_PF_REQ;
            end
          end else if (miss_valid) begin
            // The restart address is loaded now; the stale line is dropped on arrival.
            load_addr = 1'b1;
            pend_set  = 1'b1;
          end
        end
        ORV64_IC_PF_DRAIN: begin
          if (pf_resp_valid) state_nxt = ORV64_IC_PF_IDLE;
        end
        default: state_nxt = ORV64_IC_PF_IDLE;
      endcase
    end
  end

  always_comb begin
    pf_req_valid = (state == ORV64_IC_PF_REQ);
  end

  assign pf_req_addr = next_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
    end else begin
      if (load_addr)    next_addr <= miss_next;
      else if (advance) next_addr <= next_addr + LINE_BYTES;
      if (cnt_clr)      cnt <= '0;
      else if (advance) cnt <= cnt + CNT_W'(1);
      if (pend_clr)      pend <= 1'b0;
      else if (pend_set) pend <= 1'b1;
    end
  end

  logic [N_ENTRY-1:0] hit_vec;
  logic [31:0]        word_vec [N_ENTRY];

  for (genvar i = 0; i < N_ENTRY; i++) begin : g_entry
    orv64_ic_pf_entry #(
      .LINE_W (LINE_W),
      .TAG_W  (TAG_W),
      .WIDX_W (WIDX_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr_all),
      .we         (wr_en && (cnt == CNT_W'(i))),
      .wr_tag     (next_addr[ADDR_W-1:OFF_W]),
      .wr_line    (pf_resp_line),
      .probe_tag  (lookup_pc[ADDR_W-1:OFF_W]),
      .probe_word (lookup_pc[OFF_W-1:2]),
      .hit        (hit_vec[i]),
      .word       (word_vec[i])
    );
  end

  logic        any_hit;
  logic [31:0] inst_or;

  // Tags are unique, so OR-ing the already hit-gated words selects the single match.
  always_comb begin
    any_hit = 1'b0;
    inst_or = 32'd0;
    for (int i = 0; i < N_ENTRY; i++) begin
      any_hit = any_hit | hit_vec[i];
      inst_or = inst_or | word_vec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_rsp_valid <= 1'b0;
      lookup_hit       <= 1'b0;
      lookup_inst      <= 32'd0;
    end else begin
      lookup_rsp_valid <= lookup_valid;
      lookup_hit       <= lookup_valid && any_hit;
      lookup_inst      <= lookup_valid ? inst_or : 32'd0;
    end
  end

endmodule

// File: tb/tb_orv64_ic_prefetch_buf.sv
// Scoreboard bench for orv64_ic_prefetch_buf: expected requests and probe results are
// queued by directed stimulus and compared by independent monitors.
module tb_orv64_ic_prefetch_buf;

  localparam int ADDR_W = 39;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              pf_req_valid;
  logic [ADDR_W-1:0] pf_req_addr;
  logic              pf_req_ready;
  logic              pf_resp_valid;
  logic [LINE_W-1:0] pf_resp_line;
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              lookup_rsp_valid;
  logic              lookup_hit;
  logic [31:0]       lookup_inst;

  orv64_ic_prefetch_buf dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .miss_valid       (miss_valid),
    .miss_addr        (miss_addr),
    .pf_req_valid     (pf_req_valid),
    .pf_req_addr      (pf_req_addr),
    .pf_req_ready     (pf_req_ready),
    .pf_resp_valid    (pf_resp_valid),
    .pf_resp_line     (pf_resp_line),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .lookup_rsp_valid (lookup_rsp_valid),
    .lookup_hit       (lookup_hit),
    .lookup_inst      (lookup_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              hit;
    logic [31:0]       inst;
  } lk_exp_t;

  logic [ADDR_W-1:0] req_q [$];
  lk_exp_t           lk_q  [$];
  int                tests = 0;
  int                fails = 0;
  int                resp_delay = 2;

  // Memory model: word w of the line at address a holds a[31:0] + 4*w + 0xA500_0000.
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = a[31:0] + 32'(w * 4) + 32'hA500_0000;
    return l;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Request monitor: every accepted request must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && pf_req_valid && pf_req_ready) begin
        if (req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL req_unexpected: got addr 0x%0h, expected no request", pf_req_addr);
        end else begin
          check("req_addr", 64'(pf_req_addr), 64'(req_q.pop_front()));
        end
      end
    end
  end

  // Lookup monitor.
  initial begin
    lk_exp_t e;
    forever begin
      @(negedge clk);
      if (lookup_rsp_valid) begin
        if (lk_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL lookup_unexpected: got rsp_valid 1, expected 0");
        end else begin
          e = lk_q.pop_front();
          check($sformatf("lookup_hit pc=0x%0h", e.pc), 64'(lookup_hit), 64'(e.hit));
          check($sformatf("lookup_inst pc=0x%0h", e.pc), 64'(lookup_inst), 64'(e.inst));
        end
      end
    end
  end

  // Responder: returns the line resp_delay cycles after each accepted request.
  initial begin
    logic [ADDR_W-1:0] a;
    int d;
    pf_resp_valid = 1'b0;
    pf_resp_line  = '0;
    forever begin
      @(negedge clk);
      if (!rst && pf_req_valid && pf_req_ready) begin
        a = pf_req_addr;
        d = resp_delay;
        repeat (d) @(posedge clk);
        #1;
        pf_resp_valid = 1'b1;
        pf_resp_line  = line_of(a);
        @(posedge clk);
        #1;
        pf_resp_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_miss(input logic [ADDR_W-1:0] a);
    @(posedge clk); #1;
    miss_valid = 1'b1;
    miss_addr  = a;
    @(posedge clk); #1;
    miss_valid = 1'b0;
  endtask

  task automatic probe(input logic [ADDR_W-1:0] pc, input logic hit, input logic [31:0] inst);
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    lk_q.push_back('{pc: pc, hit: hit, inst: inst});
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  task automatic push_reqs(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                           input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] a3);
    req_q.push_back(a0);
    req_q.push_back(a1);
    req_q.push_back(a2);
    req_q.push_back(a3);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while (req_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_left"}, 64'(req_q.size()), 64'd0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_handshake(input string name, input logic [ADDR_W-1:0] a, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pf_req_valid && pf_req_ready && pf_req_addr == a) && n < budget);
    check({name, "_handshake_seen"}, 64'(pf_req_valid && pf_req_ready && pf_req_addr == a), 64'd1);
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    miss_valid   = 1'b0;
    miss_addr    = '0;
    pf_req_ready = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pf_req_valid", 64'(pf_req_valid), 64'd0);
    check("rst_pf_req_addr", 64'(pf_req_addr), 64'd0);
    check("rst_lookup_rsp_valid", 64'(lookup_rsp_valid), 64'd0);
    check("rst_lookup_hit", 64'(lookup_hit), 64'd0);
    check("rst_lookup_inst", 64'(lookup_inst), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic stream from a mid-line miss.
    probe(39'h1020, 1'b0, 32'h0);
    pf_req_ready = 1'b1;
    resp_delay   = 2;
    push_reqs(39'h1020, 39'h1040, 39'h1060, 39'h1080);
    pulse_miss(39'h1008);
    wait_drained("basic", 100);
    @(negedge clk);
    check("basic_idle_valid", 64'(pf_req_valid), 64'd0);

    probe(39'h104C, 1'b1, 32'hA500_104C);
    probe(39'h10A0, 1'b0, 32'h0);
    probe(39'h1080, 1'b1, 32'hA500_1080);
    probe(39'h1023, 1'b1, 32'hA500_1020);
    probe(39'h107F, 1'b1, 32'hA500_107C);
    probe(39'h1000, 1'b0, 32'h0);

    // Backpressure: five stalled cycles with a stable request.
    pf_req_ready = 1'b0;
    push_reqs(39'h2020, 39'h2040, 39'h2060, 39'h2080);
    pulse_miss(39'h2000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(pf_req_valid), 64'd1);
      check("bp_addr", 64'(pf_req_addr), 64'h2020);
    end
    @(posedge clk); #1;
    pf_req_ready = 1'b1;
    wait_drained("bp", 100);
    probe(39'h104C, 1'b0, 32'h0);
    probe(39'h2064, 1'b1, 32'hA500_2064);

    // Flush while waiting: response arrives three cycles after the flush.
    resp_delay = 4;
    req_q.push_back(39'h3020);
    pulse_miss(39'h3000);
    wait_handshake("flush_wait", 39'h3020, 20);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("flush_wait_no_req", 64'(pf_req_valid), 64'd0);
    end
    probe(39'h3020, 1'b0, 32'h0);
    probe(39'h3040, 1'b0, 32'h0);
    probe(39'h2040, 1'b0, 32'h0);
    check("flush_wait_req_q", 64'(req_q.size()), 64'd0);

    // New miss while waiting on 0x1040.
    resp_delay = 3;
    req_q.push_back(39'h1020);
    req_q.push_back(39'h1040);
    push_reqs(39'h8020, 39'h8040, 39'h8060, 39'h8080);
    pulse_miss(39'h1000);
    wait_handshake("miss_wait", 39'h1040, 40);
    @(posedge clk); #1;
    miss_valid = 1'b1;
    miss_addr  = 39'h8000;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    wait_drained("miss_wait", 100);
    probe(39'h1040, 1'b0, 32'h0);
    probe(39'h1020, 1'b0, 32'h0);
    probe(39'h8044, 1'b1, 32'hA500_8044);
    probe(39'h8080, 1'b1, 32'hA500_8080);

    // Address wrap at the top of the virtual space.
    resp_delay = 2;
    push_reqs(39'h7F_FFFF_FFE0, 39'h0, 39'h20, 39'h40);
    pulse_miss(39'h7F_FFFF_FFC0);
    wait_drained("wrap", 100);
    probe(39'h7F_FFFF_FFE4, 1'b1, 32'hA4FF_FFE4);
    probe(39'h0, 1'b1, 32'hA500_0000);
    probe(39'h44, 1'b1, 32'hA500_0044);

    // Flush while requesting: request drops the next cycle.
    pf_req_ready = 1'b0;
    pulse_miss(39'h5000);
    @(negedge clk);
    check("flush_req_valid_before", 64'(pf_req_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    pf_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_req_valid_after", 64'(pf_req_valid), 64'd0);
    end
    probe(39'h20, 1'b0, 32'h0);

    // Flush and miss together: the miss is ignored.
    @(posedge clk); #1;
    flush      = 1'b1;
    miss_valid = 1'b1;
    miss_addr  = 39'h6000;
    @(posedge clk); #1;
    flush      = 1'b0;
    miss_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_miss_valid", 64'(pf_req_valid), 64'd0);
    end

    repeat (4) @(posedge clk);
    check("final_req_q", 64'(req_q.size()), 64'd0);
    check("final_lk_q", 64'(lk_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
